// File: rtl/bus_target_pkg.sv
// rtl/bus_target_pkg.sv - shared types and widths for the burst-bus SRAM target
package bus_target_pkg;

    localparam int BURST_W = 8;
    localparam int DATA_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RD_FETCH,
        ST_READ,
        ST_RD_END,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/sram_1rw.sv
// rtl/sram_1rw.sv - single-port synchronous RAM, 1-cycle read, per-byte write enables
module sram_1rw
    import bus_target_pkg::*;
#(
    parameter int ADDR_BITS = 9
) (
    input  logic                 clock,
    input  logic                 re,
    input  logic [3:0]           we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_BITS];

    // rdata only moves on a read, so a stalled beat stays stable downstream
    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/bus_sram_target.sv
// rtl/bus_sram_target.sv - burst-bus target decoding a window onto on-chip SRAM
module bus_sram_target
    import bus_target_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int          ADDR_BITS    = 9
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [DATA_W-1:0]  address_dataIN,
    input  logic [3:0]         byte_enableIN,
    input  logic [BURST_W-1:0] burst_sizeIN,
    input  logic               read_n_writeIN,
    input  logic               begin_transactionIN,
    input  logic               end_transactionIN,
    input  logic               data_validIN,
    input  logic               busyIN,
    output logic [DATA_W-1:0]  address_dataOUT,
    output logic               data_validOUT,
    output logic               end_transactionOUT,
    output logic               busyOUT,
    output logic               errorOUT
);

    // Range sum is wide enough that offset + burst can never wrap
    localparam int SUM_W = (ADDR_BITS + 1 > BURST_W + 1) ? ADDR_BITS + 1 : BURST_W + 1;

    state_t               state;
    logic [ADDR_BITS-1:0] word_addr;
    logic [BURST_W:0]     beat_cnt;
    logic [3:0]           be_q;
    logic [BURST_W-1:0]   burst_q;

    logic [ADDR_BITS-1:0] begin_word;
    logic [SUM_W-1:0]     span;
    logic                 hit;
    logic                 last_beat;
    logic                 wr_ok;
    logic                 ram_re;
    logic [3:0]           ram_we;
    logic [ADDR_BITS-1:0] ram_addr;
    logic [DATA_W-1:0]    ram_rdata;

    assign begin_word = address_dataIN[ADDR_BITS+1:2];
    assign span       = SUM_W'(begin_word) + SUM_W'(burst_sizeIN);
    assign hit        = (address_dataIN[31:ADDR_BITS+2] == BASE_ADDRESS[31:ADDR_BITS+2])
                     && (span[SUM_W-1:ADDR_BITS] == '0);

    assign last_beat = (beat_cnt == {1'b0, burst_q});
    assign wr_ok     = (beat_cnt <= {1'b0, burst_q});

    // On an accepted read beat the next word is fetched in the same cycle
    assign ram_re   = (state == ST_RD_FETCH) || (state == ST_READ && !busyIN && !last_beat);
    assign ram_we   = (state == ST_WRITE && data_validIN && wr_ok) ? be_q : 4'b0000;
    assign ram_addr = (state == ST_READ) ? word_addr + ADDR_BITS'(1) : word_addr;

    assign address_dataOUT = data_validOUT ? ram_rdata : '0;

    sram_1rw #(
        .ADDR_BITS (ADDR_BITS)
    ) u_sram (
        .clock (clock),
        .re    (ram_re),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (address_dataIN),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state              <= ST_IDLE;
            word_addr          <= '0;
            beat_cnt           <= '0;
            be_q               <= '0;
            burst_q            <= '0;
            data_validOUT      <= 1'b0;
            end_transactionOUT <= 1'b0;
            busyOUT            <= 1'b0;
            errorOUT           <= 1'b0;
        end else begin
            data_validOUT      <= 1'b0;
            end_transactionOUT <= 1'b0;
            busyOUT            <= 1'b0;
            errorOUT           <= 1'b0;

            if (state != ST_IDLE && end_transactionIN) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (begin_transactionIN) begin
                            word_addr <= begin_word;
                            beat_cnt  <= '0;
                            be_q      <= byte_enableIN;
                            burst_q   <= burst_sizeIN;
                            if (!hit) begin
                                state    <= ST_ERROR;
                                errorOUT <= 1'b1;
                                busyOUT  <= 1'b1;
                            end else if (read_n_writeIN) begin
                                state   <= ST_RD_FETCH;
                                busyOUT <= 1'b1;
                            end else begin
                                state <= ST_WRITE;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (data_validIN && wr_ok) begin
                            word_addr <= word_addr + ADDR_BITS'(1);
                            beat_cnt  <= beat_cnt + 1'b1;
                        end
                    end
                    ST_RD_FETCH: begin
                        state         <= ST_READ;
                        data_validOUT <= 1'b1;
                        busyOUT       <= 1'b1;
                    end
                    ST_READ: begin
                        busyOUT <= 1'b1;
                        if (busyIN) begin
                            data_validOUT <= 1'b1;
                        end else if (last_beat) begin
                            state              <= ST_RD_END;
                            end_transactionOUT <= 1'b1;
                        end else begin
                            word_addr     <= word_addr + ADDR_BITS'(1);
                            beat_cnt      <= beat_cnt + 1'b1;
                            data_validOUT <= 1'b1;
                        end
                    end
                    ST_RD_END: state <= ST_IDLE;
                    ST_ERROR:  state <= ST_IDLE;
                    default:   state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bus_sram_target.sv
// tb/tb_bus_sram_target.sv - directed self-checking bench for bus_sram_target
module tb_bus_sram_target;

    localparam int          AB   = 9;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address_dataIN;
    logic [3:0]  byte_enableIN;
    logic [7:0]  burst_sizeIN;
    logic        read_n_writeIN;
    logic        begin_transactionIN;
    logic        end_transactionIN;
    logic        data_validIN;
    logic        busyIN;
    logic [31:0] address_dataOUT;
    logic        data_validOUT;
    logic        end_transactionOUT;
    logic        busyOUT;
    logic        errorOUT;

    int checks = 0;
    int errors = 0;

    logic [31:0] wq[$];
    logic [31:0] eq[$];

    bus_sram_target #(
        .BASE_ADDRESS (BASE),
        .ADDR_BITS    (AB)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .address_dataIN      (address_dataIN),
        .byte_enableIN       (byte_enableIN),
        .burst_sizeIN        (burst_sizeIN),
        .read_n_writeIN      (read_n_writeIN),
        .begin_transactionIN (begin_transactionIN),
        .end_transactionIN   (end_transactionIN),
        .data_validIN        (data_validIN),
        .busyIN              (busyIN),
        .address_dataOUT     (address_dataOUT),
        .data_validOUT       (data_validOUT),
        .end_transactionOUT  (end_transactionOUT),
        .busyOUT             (busyOUT),
        .errorOUT            (errorOUT)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        address_dataIN      = '0;
        byte_enableIN       = '0;
        burst_sizeIN        = '0;
        read_n_writeIN      = 1'b0;
        begin_transactionIN = 1'b0;
        end_transactionIN   = 1'b0;
        data_validIN        = 1'b0;
        busyIN              = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, data_validOUT, 0);
        check({tag, "_data"}, address_dataOUT, 0);
        check({tag, "_end"}, end_transactionOUT, 0);
        check({tag, "_busy"}, busyOUT, 0);
        check({tag, "_err"}, errorOUT, 0);
    endtask

    task automatic begin_phase(input logic [31:0] addr, input logic [7:0] bs,
                               input logic [3:0] be, input logic rnw);
        begin_transactionIN = 1'b1;
        address_dataIN      = addr;
        burst_sizeIN        = bs;
        byte_enableIN       = be;
        read_n_writeIN      = rnw;
        next_cycle();
        idle_inputs();
    endtask

    // Beats come from wq; end is raised with the last beat
    task automatic do_write(input logic [31:0] addr, input logic [7:0] bs, input logic [3:0] be);
        begin_phase(addr, bs, be, 1'b0);
        check("wr_err", errorOUT, 0);
        check("wr_busy", busyOUT, 0);
        for (int i = 0; i < wq.size(); i++) begin
            address_dataIN    = wq[i];
            data_validIN      = 1'b1;
            end_transactionIN = (i == wq.size() - 1);
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] bs);
        begin_phase(addr, bs, 4'h0, 1'b1);
        check("rd_fetch_valid", data_validOUT, 0);
        check("rd_fetch_busy", busyOUT, 1);
        for (int i = 0; i <= int'(bs); i++) begin
            next_cycle();
            check("rd_valid", data_validOUT, 1);
            check($sformatf("rd_data%0d", i), address_dataOUT, eq[i]);
            check("rd_end_early", end_transactionOUT, 0);
        end
        next_cycle();
        check("rd_end", end_transactionOUT, 1);
        check("rd_end_valid", data_validOUT, 0);
        check("rd_end_data", address_dataOUT, 0);
        next_cycle();
        check("rd_idle_busy", busyOUT, 0);
        check("rd_idle_end", end_transactionOUT, 0);
    endtask

    task automatic do_err(input logic [31:0] addr, input logic [7:0] bs, input logic rnw);
        begin_phase(addr, bs, 4'hF, rnw);
        check("err_pulse", errorOUT, 1);
        check("err_busy", busyOUT, 1);
        check("err_valid", data_validOUT, 0);
        address_dataIN = 32'hBAD0_BAD0;
        data_validIN   = 1'b1;
        next_cycle();
        idle_inputs();
        check("err_clear", errorOUT, 0);
        check("err_idle_busy", busyOUT, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("in_reset");
        reset = 1'b1;
        next_cycle();
        check_all_zero("post_reset");

        // Write then read back
        wq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        do_write(BASE + 32'h10, 8'd3, 4'hF);
        eq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        do_read(BASE + 32'h10, 8'd3);

        // Byte lanes
        wq = '{32'hFFFF_FFFF};
        do_write(BASE + 32'h40, 8'd0, 4'hF);
        wq = '{32'h1234_5678};
        do_write(BASE + 32'h40, 8'd0, 4'b0101);
        eq = '{32'hFF34_FF78};
        do_read(BASE + 32'h40, 8'd0);

        // Read stall: busyIN high in cycles 2-4
        begin_phase(BASE + 32'h10, 8'd1, 4'h0, 1'b1);
        check("stall_c1_valid", data_validOUT, 0);
        for (int c = 2; c <= 4; c++) begin
            next_cycle();
            busyIN = 1'b1;
            check($sformatf("stall_c%0d_valid", c), data_validOUT, 1);
            check($sformatf("stall_c%0d_data", c), address_dataOUT, 32'hA0);
        end
        next_cycle();
        busyIN = 1'b0;
        check("stall_c5_data", address_dataOUT, 32'hA0);
        next_cycle();
        check("stall_c6_valid", data_validOUT, 1);
        check("stall_c6_data", address_dataOUT, 32'hA1);
        next_cycle();
        check("stall_c7_end", end_transactionOUT, 1);
        next_cycle();

        // Decode errors leave memory untouched
        wq = '{32'h1111_1111};
        do_write(BASE + 32'h0, 8'd0, 4'hF);
        wq = '{32'h7777_7777};
        do_write(BASE + 32'h7FC, 8'd0, 4'hF);
        do_err(BASE + 32'h800, 8'd0, 1'b0);
        do_err(BASE + 32'h7FC, 8'd1, 1'b0);
        do_err(32'h0000_0010, 8'd0, 1'b1);
        eq = '{32'h1111_1111};
        do_read(BASE + 32'h0, 8'd0);
        eq = '{32'h7777_7777};
        do_read(BASE + 32'h7FC, 8'd0);

        // Extra write beats are dropped once the burst is complete
        wq = '{32'h99};
        do_write(BASE + 32'h308, 8'd0, 4'hF);
        wq = '{32'hE0, 32'hE1, 32'hE2};
        do_write(BASE + 32'h300, 8'd1, 4'hF);
        eq = '{32'hE0, 32'hE1, 32'h99};
        do_read(BASE + 32'h300, 8'd2);

        // Abort in cycle 3 of an 8-beat read
        wq = '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5, 32'hC6, 32'hC7};
        do_write(BASE + 32'h100, 8'd7, 4'hF);
        begin_phase(BASE + 32'h100, 8'd7, 4'h0, 1'b1);
        next_cycle();
        check("abort_c2_data", address_dataOUT, 32'hC0);
        next_cycle();
        check("abort_c3_data", address_dataOUT, 32'hC1);
        end_transactionIN = 1'b1;
        next_cycle();
        end_transactionIN = 1'b0;
        check_all_zero("abort_c4");
        eq = '{32'hC1, 32'hC2, 32'hC3};
        do_read(BASE + 32'h104, 8'd2);

        // Asynchronous reset mid-write
        begin_phase(BASE + 32'h200, 8'd3, 4'hF, 1'b0);
        address_dataIN = 32'h55;
        data_validIN   = 1'b1;
        next_cycle();
        address_dataIN = 32'h66;
        next_cycle();
        idle_inputs();
        #2 reset = 1'b0;
        #1 check_all_zero("rst_wr");
        #2 reset = 1'b1;
        next_cycle();

        // Asynchronous reset mid-read
        begin_phase(BASE + 32'h10, 8'd3, 4'h0, 1'b1);
        next_cycle();
        check("rst_rd_valid_before", data_validOUT, 1);
        #2 reset = 1'b0;
        #1 check_all_zero("rst_rd");
        #2 reset = 1'b1;
        next_cycle();
        check_all_zero("rst_rd_idle");

        eq = '{32'h55, 32'h66};
        do_read(BASE + 32'h200, 8'd1);
        eq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        do_read(BASE + 32'h10, 8'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
